// File: rtl/spram_pipe.sv
// -----------------------------------------------------------------------------
// spram_pipe
//   Parametrised single-port synchronous RAM with per-byte write enables,
//   a configurable read pipeline, selectable read-during-write result and a
//   hardware clear sweep that zeroes every word after reset.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   address width, DEPTH = 2**ADDR_WIDTH words
//   READ_LATENCY cycles from accepted read to data_out (1..3)
//   RDW_MODE     read-during-write result: 0 = old data, 1 = merged new data
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous active-high reset
//   address      word address for read and write
//   data_in      write data
//   write_enable write request
//   byte_enable  per-byte write mask, bit i gates data_in[8i+7:8i]
//   read_enable  read request
//   data_out     read data, holds its value between reads
//   data_valid   one-cycle pulse when data_out carries a new read result
//   busy         high during reset and the clear sweep; requests are ignored
// -----------------------------------------------------------------------------
module spram_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   count_reg;
  logic [ADDR_WIDTH-1:0]   count_next;
  logic                    busy_reg;

  // ---------------------------------------------------------------------------
  // Clear-sweep controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      CLEAR: begin
        count_next = count_reg + 1'b1;
        // The last word of the array is being cleared this cycle.
        if (count_reg == '1) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= CLEAR;
      count_reg <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      busy_reg  <= (state_next == CLEAR);
    end
  end

  assign busy = busy_reg;

  // ---------------------------------------------------------------------------
  // Request qualification: nothing is accepted during reset or the sweep.
  // ---------------------------------------------------------------------------
  logic                  sweep_write;
  logic                  write_accept;
  logic                  read_accept;
  logic [ADDR_WIDTH-1:0] write_address;

  assign sweep_write   = (state_reg == CLEAR) && !reset;
  assign write_accept  = (state_reg == READY) && !reset && write_enable;
  assign read_accept   = (state_reg == READY) && !reset && read_enable;
  assign write_address = sweep_write ? count_reg : address;

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so each lane maps onto its own
  // block RAM write port; the registered read forms pipeline stage 0.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] stage0_data;

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] read_byte_reg;
      logic       lane_write;
      logic [7:0] lane_wdata;

      assign lane_write = sweep_write || (write_accept && byte_enable[gi]);
      assign lane_wdata = sweep_write ? 8'h00 : data_in[8*gi +: 8];

      always_ff @(posedge clock) begin
        if (lane_write) begin
          mem_lane[write_address] <= lane_wdata;
        end
        if (read_accept) begin
          // New-data mode forwards the incoming byte of a simultaneous write;
          // otherwise the array read returns the pre-write contents.
          if ((RDW_MODE != 0) && write_accept && byte_enable[gi]) begin
            read_byte_reg <= data_in[8*gi +: 8];
          end else begin
            read_byte_reg <= mem_lane[address];
          end
        end
      end

      assign stage0_data[8*gi +: 8] = read_byte_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 0 is the RAM read register, stages 1..L-1 follow.
  // Data stages carry no reset; only the valid bits are flushed.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   stage_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid_reg;

  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_data[gi] = stage0_data;
      end else begin : g_next
        logic [DATA_WIDTH-1:0] stage_reg;
        always_ff @(posedge clock) begin
          stage_reg <= stage_data[gi-1];
        end
        assign stage_data[gi] = stage_reg;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= read_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: loads only on a valid final stage, holds otherwise.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      data_valid_reg <= pipe_valid_reg[READ_LATENCY-1];
      if (pipe_valid_reg[READ_LATENCY-1]) begin
        data_out_reg <= stage_data[READ_LATENCY-1];
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;

endmodule

// File: tb/tb_spram_pipe.sv
// -----------------------------------------------------------------------------
// tb_spram_pipe
//   Directed bench for spram_pipe. Two instances share one stimulus stream:
//     dut_a : 16-bit data, READ_LATENCY=3, RDW_MODE=0 (old data)
//     dut_b : 16-bit data, READ_LATENCY=2, RDW_MODE=1 (merged new data)
//   Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spram_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic        write_enable;
  logic [1:0]  byte_enable;
  logic        read_enable;

  logic [15:0] data_out_a;
  logic        data_valid_a;
  logic        busy_a;
  logic [15:0] data_out_b;
  logic        data_valid_b;
  logic        busy_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  spram_pipe #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (8),
    .READ_LATENCY(3),
    .RDW_MODE    (0)
  ) dut_a (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .write_enable(write_enable),
    .byte_enable (byte_enable),
    .read_enable (read_enable),
    .data_out    (data_out_a),
    .data_valid  (data_valid_a),
    .busy        (busy_a)
  );

  spram_pipe #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (8),
    .READ_LATENCY(2),
    .RDW_MODE    (1)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .write_enable(write_enable),
    .byte_enable (byte_enable),
    .read_enable (read_enable),
    .data_out    (data_out_b),
    .data_valid  (data_valid_b),
    .busy        (busy_b)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] observed,
                     input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, cross the rising edge,
  // then drop the request strobes.
  task automatic op(input logic we, input logic re, input logic [7:0] a,
                    input logic [15:0] d, input logic [1:0] be);
    write_enable = we;
    read_enable  = re;
    address      = a;
    data_in      = d;
    byte_enable  = be;
    @(negedge clock);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  // Issue a read (optionally with a simultaneous write) at edge N and check
  // both instances at their own latency: B after edge N+2, A after edge N+3.
  task automatic rd_check(input string tag, input logic we, input logic [7:0] a,
                          input logic [15:0] d, input logic [1:0] be,
                          input logic [15:0] exp_a, input logic [15:0] exp_b);
    op(we, 1'b1, a, d, be);
    @(negedge clock);
    chk({tag, "/a_valid_n1"}, 16'(data_valid_a), 16'd0);
    chk({tag, "/b_valid_n1"}, 16'(data_valid_b), 16'd0);
    @(negedge clock);
    chk({tag, "/b_valid_n2"}, 16'(data_valid_b), 16'd1);
    chk({tag, "/b_data_n2"},  data_out_b, exp_b);
    chk({tag, "/a_valid_n2"}, 16'(data_valid_a), 16'd0);
    @(negedge clock);
    chk({tag, "/a_valid_n3"}, 16'(data_valid_a), 16'd1);
    chk({tag, "/a_data_n3"},  data_out_a, exp_a);
    chk({tag, "/b_valid_n3"}, 16'(data_valid_b), 16'd0);
    chk({tag, "/b_hold_n3"},  data_out_b, exp_b);
    $display("read %s addr=%h a=%h b=%h", tag, a, data_out_a, data_out_b);
  endtask

  // Called at the falling edge where reset has just been released. Counts
  // busy-high samples per instance; optionally keeps a write and a read of
  // address 0x03 asserted throughout to prove they are dropped.
  task automatic sweep_count(input string tag, input logic poke);
    int cnt_a = 0;
    int cnt_b = 0;
    int guard = 0;
    logic valid_seen = 1'b0;
    write_enable = poke;
    read_enable  = poke;
    address      = 8'h03;
    data_in      = 16'h0077;
    byte_enable  = 2'b11;
    while ((busy_a || busy_b) && guard < 1000) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (data_valid_a || data_valid_b) valid_seen = 1'b1;
      guard++;
      @(negedge clock);
    end
    write_enable = 1'b0;
    read_enable  = 1'b0;
    chk({tag, "/busy_cycles_a"}, 16'(cnt_a), 16'd256);
    chk({tag, "/busy_cycles_b"}, 16'(cnt_b), 16'd256);
    chk({tag, "/no_valid_while_busy"}, 16'(valid_seen), 16'd0);
    $display("sweep %s busy_a=%0d busy_b=%0d", tag, cnt_a, cnt_b);
  endtask

  initial begin
    reset        = 1'b1;
    address      = '0;
    data_in      = '0;
    write_enable = 1'b0;
    byte_enable  = '0;
    read_enable  = 1'b0;

    // Reset values after three reset edges.
    repeat (3) @(negedge clock);
    chk("rst/a_data",  data_out_a, 16'h0000);
    chk("rst/a_valid", 16'(data_valid_a), 16'd0);
    chk("rst/a_busy",  16'(busy_a), 16'd1);
    chk("rst/b_data",  data_out_b, 16'h0000);
    chk("rst/b_valid", 16'(data_valid_b), 16'd0);
    chk("rst/b_busy",  16'(busy_b), 16'd1);

    // Clear sweep with a write of 0x77 to 0x03 held throughout.
    reset = 1'b0;
    sweep_count("sweep1", 1'b1);
    rd_check("clr_03", 1'b0, 8'h03, 16'h0, 2'b00, 16'h0000, 16'h0000);
    rd_check("clr_00", 1'b0, 8'h00, 16'h0, 2'b00, 16'h0000, 16'h0000);
    rd_check("clr_7f", 1'b0, 8'h7F, 16'h0, 2'b00, 16'h0000, 16'h0000);
    rd_check("clr_ff", 1'b0, 8'hFF, 16'h0, 2'b00, 16'h0000, 16'h0000);

    // Write then read on the next edge; data_out holds afterwards.
    op(1'b1, 1'b0, 8'h10, 16'h00A5, 2'b11);
    rd_check("wr_rd_10", 1'b0, 8'h10, 16'h0, 2'b00, 16'h00A5, 16'h00A5);
    repeat (2) @(negedge clock);
    chk("hold/a_data",  data_out_a, 16'h00A5);
    chk("hold/a_valid", 16'(data_valid_a), 16'd0);
    chk("hold/b_data",  data_out_b, 16'h00A5);

    // Byte enables, including an all-zero mask.
    op(1'b1, 1'b0, 8'h20, 16'h1234, 2'b11);
    op(1'b1, 1'b0, 8'h20, 16'hABCD, 2'b01);
    rd_check("be_lo", 1'b0, 8'h20, 16'h0, 2'b00, 16'h12CD, 16'h12CD);
    op(1'b1, 1'b0, 8'h20, 16'hFFFF, 2'b00);
    rd_check("be_none", 1'b0, 8'h20, 16'h0, 2'b00, 16'h12CD, 16'h12CD);
    op(1'b1, 1'b0, 8'h20, 16'h5699, 2'b10);
    rd_check("be_hi", 1'b0, 8'h20, 16'h0, 2'b00, 16'h56CD, 16'h56CD);

    // Read-during-write: old data on A, new/merged data on B.
    op(1'b1, 1'b0, 8'h05, 16'h0011, 2'b11);
    rd_check("rdw_full", 1'b1, 8'h05, 16'h0022, 2'b11, 16'h0011, 16'h0022);
    rd_check("rdw_after", 1'b0, 8'h05, 16'h0, 2'b00, 16'h0022, 16'h0022);
    rd_check("rdw_merge", 1'b1, 8'h05, 16'h9999, 2'b10, 16'h0022, 16'h9922);
    rd_check("rdw_after2", 1'b0, 8'h05, 16'h0, 2'b00, 16'h9922, 16'h9922);

    // Reset one cycle after an accepted read: the read is discarded.
    op(1'b0, 1'b1, 8'h10, 16'h0, 2'b00);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst/a_valid", 16'(data_valid_a), 16'd0);
    chk("midrst/b_valid", 16'(data_valid_b), 16'd0);
    chk("midrst/a_data",  data_out_a, 16'h0000);
    chk("midrst/b_data",  data_out_b, 16'h0000);
    chk("midrst/a_busy",  16'(busy_a), 16'd1);
    chk("midrst/b_busy",  16'(busy_b), 16'd1);
    @(negedge clock);
    chk("midrst2/a_valid", 16'(data_valid_a), 16'd0);
    chk("midrst2/b_valid", 16'(data_valid_b), 16'd0);

    // Reset again mid-sweep; the sweep must restart from address 0.
    reset = 1'b0;
    repeat (100) @(negedge clock);
    chk("midsweep/a_busy", 16'(busy_a), 16'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sweep_count("sweep2", 1'b0);
    rd_check("clr2_10", 1'b0, 8'h10, 16'h0, 2'b00, 16'h0000, 16'h0000);
    rd_check("clr2_05", 1'b0, 8'h05, 16'h0, 2'b00, 16'h0000, 16'h0000);

    // Streaming: fill every word, then read 0..255 back to back.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      op(1'b1, 1'b0, ib, {ib ^ 8'h5A, ib}, 2'b11);
    end
    for (int c = 0; c <= 260; c++) begin
      int k;
      logic [7:0] ia;
      logic [7:0] ib;
      logic exp_va;
      logic exp_vb;
      k = c - 1;
      exp_vb = (k >= 2) && (k <= 257);
      exp_va = (k >= 3) && (k <= 258);
      chk("stream/b_valid", 16'(data_valid_b), 16'(exp_vb));
      chk("stream/a_valid", 16'(data_valid_a), 16'(exp_va));
      if (exp_vb) begin
        ib = 8'(k - 2);
        chk("stream/b_data", data_out_b, {ib ^ 8'h5A, ib});
      end
      if (exp_va) begin
        ia = 8'(k - 3);
        chk("stream/a_data", data_out_a, {ia ^ 8'h5A, ia});
      end
      read_enable = (c < 256);
      address     = 8'(c);
      @(negedge clock);
    end
    read_enable = 1'b0;
    $display("stream done a_last=%h b_last=%h", data_out_a, data_out_b);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spram_pipe.md
# spram_pipe

Parametrised single-port synchronous RAM: the next generation of the team's 8-bit single-port RAM, generalised in data/address width, with per-byte write enables, configurable read pipeline latency, selectable read-during-write behaviour and a hardware clear sweep after reset. It sits as the DUT behind the existing RAM verification environment. It keeps that environment's clock, reset, address, data_in, read_enable, write_enable and data_out signals, and adds byte_enable, data_valid and busy.

## Interface
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1: cycles from accepted read to data_out; legal 1..3.
- RDW_MODE, 0: read-during-write result; 0 = old data, 1 = new data.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; one clock, no other clock or async reset.
- address  input  ADDR_WIDTH  word address for read and write.
- data_in  input  DATA_WIDTH  write data.
- write_enable  input  1  write request.
- byte_enable  input  DATA_WIDTH/8  per-byte write mask; bit i gates data_in[8i+7:8i].
- read_enable  input  1  read request.
- data_out  output  DATA_WIDTH  read data; holds last value between reads.
- data_valid  output  1  one-cycle pulse when data_out carries a new read result.
- busy  output  1  high during reset and the clear sweep; all requests are ignored.

## Operation
- States: CLEAR and READY.
- Reset high at an edge:
  - enter CLEAR with the sweep counter at 0.
  - flush the read pipeline.
  - data_out=0, data_valid=0, busy=1.
- CLEAR:
  - each cycle with reset low, write 0 to all bytes of mem[counter] and increment the counter.
  - after writing DEPTH-1, move to READY; busy=0 from the next cycle.
- READY, write: write_enable=1 writes mem[address] byte i only where byte_enable[i]=1. write_enable=1 with byte_enable=0 is a no-op write.
- READY, read: read_enable=1 captures mem[address] into the read pipeline.
- Simultaneous read_enable and write_enable, same cycle (single port, one address):
  - the write is performed.
  - the read returns pre-write data if RDW_MODE=0.
  - if RDW_MODE=1, the read returns merged data: new bytes where byte_enable=1, old bytes elsewhere.
- Read pipeline:
  - a shift of READY_LATENCY stages, each carrying {valid, data}.
  - data_out loads only when the final stage is valid; otherwise it holds.
- Requests presented while busy=1 are dropped: no memory change, no data_valid.
- Reset mid-sweep or mid-read:
  - the sweep restarts from address 0.
  - in-flight reads are discarded and never produce data_valid.
- Address width is exact: there is no out-of-range address and no wrap logic beyond the natural ADDR_WIDTH range.
- Back-to-back reads are accepted every cycle: full throughput, no stalls.

## Timing
- Reset values: data_out=0, data_valid=0, busy=1.
- If reset is first seen low at edge R:
  - the sweep writes address k at edge R+k.
  - busy falls after edge R+DEPTH-1.
  - the first request is accepted at edge R+DEPTH.
- A read accepted at edge N gives data_out and data_valid=1 after edge N+READ_LATENCY-1+1, i.e. visible in cycle N+READ_LATENCY.
  - data_valid drops the following cycle unless another read was accepted at N+1.
- A write at edge N is visible to a read accepted at edge N+1 or later. For a read at edge N, RDW_MODE applies.
- busy is a registered output. data_out and data_valid come directly from the final pipeline register; there is no combinational path from inputs to outputs.

## Test plan
- Clear sweep:
  - stimulus: defaults; hold reset 3 cycles, release; count busy-high cycles after release.
  - required: busy=1 for exactly 256 cycles.
  - stimulus: then read addresses 0, 127, 255.
  - required: all return 0x00 with data_valid pulses.
- Write/read latency:
  - stimulus: READY_LATENCY=3; write 0xA5 to 0x10; at the next edge read 0x10.
  - required: data_out=0xA5 with data_valid=1 exactly 3 cycles after the read edge; data_out holds 0xA5 afterwards.
- Byte enables:
  - stimulus: DATA_WIDTH=16; write 0x1234 with byte_enable=2'b11, then 0xABCD with byte_enable=2'b01 to the same address; read it back.
  - required: 0x12CD.
- Read-during-write:
  - stimulus: mem[5]=0x11; on the same edge, write 0x22 to 5 with read_enable=1.
  - required: returns 0x11 for RDW_MODE=0, 0x22 for RDW_MODE=1; a later read returns 0x22 in both modes.
- Busy drop and mid-reset:
  - stimulus: write 0x77 to 0x03 during the sweep.
  - required: a later read returns 0x00.
  - stimulus: assert reset one cycle after accepting a read with READ_LATENCY=2.
  - required: no data_valid; data_out=0; busy=1; the sweep restarts.
- Streaming:
  - stimulus: 256 consecutive read cycles over addresses 0..255 after writing mem[i]=i.
  - required: data_valid high for 256 consecutive cycles, data_out sequencing 0x00..0xFF with no gaps.
